// File: rtl/pwm_edge_capture.sv
// PWM edge capture: timestamps level changes on NCH PWM inputs during a
// bounded capture run and queues one record per cycle into a FIFO.
module pwm_edge_capture #(
    parameter int NCH   = 4,
    parameter int TS_W  = 24,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            pwm_in,
    input  logic                      start,
    input  logic                      stop,
    input  logic [31:0]               duration,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [2+2*NCH+TS_W-1:0]   rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int RW = 2 + 2*NCH + TS_W;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] KIND_EDGE  = 2'b00;
    localparam logic [1:0] KIND_START = 2'b01;
    localparam logic [1:0] KIND_WRAP  = 2'b10;
    localparam logic [1:0] KIND_END   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NCH-1:0]    prev_q, prev_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [31:0]       cyc_q, cyc_d;
    logic              busy_q, done_q;

    logic [NCH-1:0]    chg;
    logic              end_cond;
    logic              wr_en;
    logic              flush;
    logic [RW-1:0]     wr_rec;

    logic [RW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [AW:0]       count_base;
    logic              overflow_q, overflow_d;
    logic [AW-1:0]     wr_addr;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              drop;

    // Capture FSM: decides the next state, counter updates and which record (if any) to write
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        ts_d     = ts_q;
        cyc_d    = cyc_q;
        wr_en    = 1'b0;
        flush    = 1'b0;
        wr_rec   = '0;
        chg      = pwm_in ^ prev_q;
        end_cond = stop || ((duration != 32'd0) && (cyc_q == duration));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    flush   = 1'b1;
                    prev_d  = pwm_in;
                    wr_en   = 1'b1;
                    wr_rec  = {KIND_START, {NCH{1'b1}}, pwm_in, {TS_W{1'b0}}};
                    ts_d    = TS_W'(1);
                    cyc_d   = 32'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                prev_d = pwm_in;
                ts_d   = ts_q + TS_W'(1);
                cyc_d  = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
                if (end_cond) begin
                    wr_en   = 1'b1;
                    wr_rec  = {KIND_END, chg, pwm_in, ts_q};
                    state_d = DONE;
                end else if (ts_q == '0) begin
                    wr_en  = 1'b1;
                    wr_rec = {KIND_WRAP, chg, pwm_in, ts_q};
                end else if (chg != '0) begin
                    wr_en  = 1'b1;
                    wr_rec = {KIND_EDGE, chg, pwm_in, ts_q};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, timestamp, cycle counter and status flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            ts_q    <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            ts_q    <= ts_d;
            cyc_q   <= cyc_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // FIFO bookkeeping: a start flush empties the queue before the START record lands at slot 0
    always_comb begin
        fifo_full  = (count_q == DEPTH_CNT);
        pop        = (count_q != '0) && rd_ready && !flush;
        push       = wr_en && (flush || !fifo_full);
        drop       = wr_en && !flush && fifo_full;
        wr_addr    = flush ? '0 : wr_ptr_q;
        count_base = flush ? '0 : count_q;
        rd_ptr_d   = flush ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
        wr_ptr_d   = push ? wr_addr + AW'(1) : wr_addr;
        count_d    = count_base;
        if (push && !pop) begin
            count_d = count_base + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_base - (AW+1)'(1);
        end
        overflow_d = flush ? 1'b0 : (overflow_q | drop);
    end

    // FIFO pointer, occupancy and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage; contents are only meaningful between the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr] <= wr_rec;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pwm_edge_capture.sv
// Scoreboard bench for pwm_edge_capture with NCH=4, TS_W=8, DEPTH=8.
module tb_pwm_edge_capture;

    localparam int NCH   = 4;
    localparam int TS_W  = 8;
    localparam int DEPTH = 8;
    localparam int RW    = 2 + 2*NCH + TS_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    pwm_in;
    logic              start;
    logic              stop;
    logic [31:0]       duration;
    logic              rd_ready;
    logic              rd_valid;
    logic [RW-1:0]     rd_data;
    logic              busy;
    logic              done;
    logic              overflow;

    int                testsRun = 0;
    int                testsFailed = 0;
    logic [RW-1:0]     expQ [$];
    logic [RW-1:0]     expRec;

    pwm_edge_capture #(
        .NCH   (NCH),
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .start    (start),
        .stop     (stop),
        .duration (duration),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mkRec(input logic [1:0] kind, input logic [3:0] mask,
                                            input logic [3:0] level, input logic [7:0] ts);
        return {kind, mask, level, ts};
    endfunction

    task automatic pushExp(input logic [1:0] kind, input logic [3:0] mask,
                           input logic [3:0] level, input logic [7:0] ts);
        expQ.push_back(mkRec(kind, mask, level, ts));
    endtask

    // Drive one cycle of inputs, let the next rising edge consume them, then drop the pulses
    task automatic applyStimulus(input logic [3:0] pwm, input logic st, input logic sp);
        pwm_in = pwm;
        start  = st;
        stop   = sp;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic waitDrain(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0 && !rd_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL %s: drain timed out, rd_valid=%0b, %0d records still expected",
                     name, rd_valid, expQ.size());
        end
    endtask

    // Monitor: every record the DUT hands over is compared with the oldest expected record
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL record: got unexpected %h, none expected", rd_data);
            end else begin
                expRec = expQ.pop_front();
                if (rd_data !== expRec) begin
                    testsFailed++;
                    $display("[TB] FAIL record: got %h, expected %h", rd_data, expRec);
                end
            end
        end
    end

    // Watchdog so a stuck run still reports
    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        rst      = 1'b1;
        pwm_in   = '0;
        start    = 1'b0;
        stop     = 1'b0;
        duration = 32'd0;
        rd_ready = 1'b1;
        #2;
        checkOutput("rstValid", 32'(rd_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstOverflow", 32'(overflow), 32'd0);
        #10;
        rst = 1'b0;

        // stop while idle does nothing
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("idleStopBusy", 32'(busy), 32'd0);
        checkOutput("idleStopDone", 32'(done), 32'd0);
        checkOutput("idleStopValid", 32'(rd_valid), 32'd0);

        // run 1: duration 10, ch0 falls at ts 3
        duration = 32'd10;
        pushExp(2'b01, 4'b1111, 4'b0101, 8'd0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("run1Busy", 32'(busy), 32'd1);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        pushExp(2'b00, 4'b0001, 4'b0100, 8'd3);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        for (int i = 4; i <= 9; i++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
        end
        checkOutput("run1BusyBeforeEnd", 32'(busy), 32'd1);
        pushExp(2'b11, 4'b0000, 4'b0100, 8'd10);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("run1Done", 32'(done), 32'd1);
        checkOutput("run1BusyAfter", 32'(busy), 32'd0);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        checkOutput("doneStopDone", 32'(done), 32'd1);
        waitDrain("run1Drain", 20);

        // run 2: unlimited, ch1+ch2 together at ts 5, ignored start at ts 2, stop at ts 7
        duration = 32'd0;
        pushExp(2'b01, 4'b1111, 4'b0000, 8'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("runStartBusy", 32'(busy), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        pushExp(2'b00, 4'b0110, 4'b0110, 8'd5);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        pushExp(2'b11, 4'b0000, 4'b0110, 8'd7);
        applyStimulus(4'b0110, 1'b0, 1'b1);
        checkOutput("run2Done", 32'(done), 32'd1);
        waitDrain("run2Drain", 20);

        // run 3: duration 300 without edges, timestamp wraps once
        duration = 32'd300;
        pushExp(2'b01, 4'b1111, 4'b0011, 8'd0);
        pushExp(2'b10, 4'b0000, 4'b0011, 8'd0);
        pushExp(2'b11, 4'b0000, 4'b0011, 8'd44);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        for (int i = 1; i <= 299; i++) begin
            applyStimulus(4'b0011, 1'b0, 1'b0);
        end
        checkOutput("run3BusyAt299", 32'(busy), 32'd1);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        checkOutput("run3Done", 32'(done), 32'd1);
        waitDrain("run3Drain", 20);

        // run 4: consumer stalled, ch0 toggles every cycle until the FIFO overflows
        duration = 32'd0;
        rd_ready = 1'b0;
        pushExp(2'b01, 4'b1111, 4'b0000, 8'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("run4ValidAfterStart", 32'(rd_valid), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] lvl;
            lvl = (k % 2 == 1) ? 4'b0001 : 4'b0000;
            if (k <= 7) begin
                pushExp(2'b00, 4'b0001, lvl, 8'(k));
            end
            applyStimulus(lvl, 1'b0, 1'b0);
            if (k == 7) begin
                checkOutput("ovfAfter8", 32'(overflow), 32'd0);
            end
            if (k == 8) begin
                checkOutput("ovfAfter9", 32'(overflow), 32'd1);
            end
        end
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("run4Done", 32'(done), 32'd1);
        rd_ready = 1'b1;
        waitDrain("run4Drain", 30);
        checkOutput("run4ValidEmpty", 32'(rd_valid), 32'd0);
        checkOutput("run4OvfSticky", 32'(overflow), 32'd1);

        // run 5: reset pulse at ts 4, then a clean restart
        pushExp(2'b01, 4'b1111, 4'b0000, 8'd0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        pwm_in = 4'b1111;
        rst = 1'b1;
        #2;
        checkOutput("midRstValid", 32'(rd_valid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b0101, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("postRstNoRecord", 32'(rd_valid), 32'd0);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        pushExp(2'b01, 4'b1111, 4'b1010, 8'd0);
        applyStimulus(4'b1010, 1'b1, 1'b0);
        pushExp(2'b11, 4'b0000, 4'b1010, 8'd1);
        applyStimulus(4'b1010, 1'b0, 1'b1);
        waitDrain("run5Drain", 20);

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
